// File: rtl/sparc_ifu_lfsr_pkg.sv
// Shared LFSR constants, maximal-length tap table and the Fibonacci step function
// used by the IFU victim-way selector.
package sparc_ifu_lfsr_pkg;

  localparam int unsigned LFSR_MAX_W     = 16;
  localparam logic [4:0]  LFSR_TAPS_DFLT = 5'b10010;
  localparam logic [4:0]  LFSR_SEED_DFLT = 5'b11111;

  // Known maximal-length tap masks; zero for widths without a tabulated entry.
  function automatic logic [LFSR_MAX_W-1:0] lfsr_max_taps(input int unsigned w);
    logic [LFSR_MAX_W-1:0] taps;
    case (w)
      5:       taps = 16'h0012;
      7:       taps = 16'h0041;
      8:       taps = 16'h00B8;
      default: taps = 16'h0000;
    endcase
    return taps;
  endfunction

  // Shift toward the MSB with the tap XOR entering bit 0; callers truncate to their width.
  function automatic logic [LFSR_MAX_W-1:0] lfsr_step(input logic [LFSR_MAX_W-1:0] q,
                                                      input logic [LFSR_MAX_W-1:0] taps);
    return {q[LFSR_MAX_W-2:0], ^(q & taps)};
  endfunction

endpackage

// File: rtl/sparc_ifu_wsel_pick.sv
// Combinational victim search: lowest invalid way first, otherwise the first
// unlocked way rotating upward from rand_idx; falls back to rand_idx when all are locked.
module sparc_ifu_wsel_pick #(
  parameter int unsigned OUT_W = 2
) (
  input  logic [OUT_W-1:0]      rand_idx,
  input  logic [(2**OUT_W)-1:0] way_vld,
  input  logic [(2**OUT_W)-1:0] way_lock,
  output logic [OUT_W-1:0]      idx_c,
  output logic [(2**OUT_W)-1:0] oh_c,
  output logic                  all_locked_c
);

  localparam int unsigned NWAYS = 2**OUT_W;

  logic [OUT_W-1:0] inv_idx;
  logic [OUT_W-1:0] unl_idx;
  logic [OUT_W-1:0] cand;
  logic             any_inv;
  logic             any_unl;

  // Descending loops so the lowest index / smallest rotation wins.
  always_comb begin
    inv_idx = '0;
    unl_idx = rand_idx;
    cand    = '0;
    any_inv = 1'b0;
    any_unl = 1'b0;
    for (int i = NWAYS - 1; i >= 0; i--) begin
      if (!way_vld[i]) begin
        inv_idx = OUT_W'(i);
        any_inv = 1'b1;
      end
    end
    for (int k = NWAYS - 1; k >= 0; k--) begin
      cand = rand_idx + OUT_W'(k);
      if (!way_lock[cand]) begin
        unl_idx = cand;
        any_unl = 1'b1;
      end
    end
  end

  always_comb begin
    idx_c        = rand_idx;
    all_locked_c = 1'b0;
    if (any_inv) begin
      idx_c = inv_idx;
    end else if (any_unl) begin
      idx_c = unl_idx;
    end else begin
      all_locked_c = 1'b1;
    end
    oh_c        = '0;
    oh_c[idx_c] = 1'b1;
  end

endmodule

// File: rtl/sparc_ifu_lfsr_wsel.sv
// Pseudo-random IFU fill victim-way selector with registered request/response.
// Optional zero-state recovery via IFU_LFSR_LOCKUP_RECOVER_EN.
module sparc_ifu_lfsr_wsel
  import sparc_ifu_lfsr_pkg::*;
#(
  parameter int unsigned       WIDTH = 5,
  parameter logic [WIDTH-1:0]  TAPS  = WIDTH'(LFSR_TAPS_DFLT),
  parameter logic [WIDTH-1:0]  SEED  = {WIDTH{1'b1}},
  parameter int unsigned       OUT_W = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  seed_ld,
  input  logic [WIDTH-1:0]      seed_val,
  input  logic                  req,
  input  logic [(2**OUT_W)-1:0] way_vld,
  input  logic [(2**OUT_W)-1:0] way_lock,
  output logic                  victim_vld,
  output logic [OUT_W-1:0]      victim,
  output logic [(2**OUT_W)-1:0] victim_oh,
  output logic                  all_locked,
`ifdef IFU_LFSR_LOCKUP_RECOVER_EN
  output logic                  lockup_recov,
`endif
  output logic [WIDTH-1:0]      lfsr_q
);

  localparam int unsigned NWAYS = 2**OUT_W;

  logic [WIDTH-1:0] q_step;
  logic [WIDTH-1:0] q_nxt;
  logic [OUT_W-1:0] rand_idx;
  logic [OUT_W-1:0] pick_idx_c;
  logic [NWAYS-1:0] pick_oh_c;
  logic             pick_all_locked_c;
  logic             lockup_c;

  always_comb begin
    q_step = WIDTH'(lfsr_step(LFSR_MAX_W'(lfsr_q), LFSR_MAX_W'(TAPS)));
  end

  // Even state bits form the random way index.
  always_comb begin
    rand_idx = '0;
    for (int k = 0; k < int'(OUT_W); k++) begin
      rand_idx[k] = lfsr_q[2*k];
    end
  end

`ifdef IFU_LFSR_LOCKUP_RECOVER_EN
  assign lockup_c = (lfsr_q == '0) && !seed_ld;
`else
  assign lockup_c = 1'b0;
`endif

  always_comb begin
    q_nxt = lfsr_q;
    if (seed_ld) begin
      q_nxt = seed_val;
    end else if (lockup_c) begin
      q_nxt = SEED;
    end else if (req) begin
      q_nxt = q_step;
    end
  end

  sparc_ifu_wsel_pick #(
    .OUT_W (OUT_W)
  ) u_pick (
    .rand_idx     (rand_idx),
    .way_vld      (way_vld),
    .way_lock     (way_lock),
    .idx_c        (pick_idx_c),
    .oh_c         (pick_oh_c),
    .all_locked_c (pick_all_locked_c)
  );

  // Response fields hold until the next accepted request.
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q     <= SEED;
      victim_vld <= 1'b0;
      victim     <= '0;
      victim_oh  <= '0;
      all_locked <= 1'b0;
    end else begin
      lfsr_q     <= q_nxt;
      victim_vld <= req;
      if (req) begin
        victim     <= pick_idx_c;
        victim_oh  <= pick_oh_c;
        all_locked <= pick_all_locked_c;
      end
    end
  end

`ifdef IFU_LFSR_LOCKUP_RECOVER_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      lockup_recov <= 1'b0;
    end else begin
      lockup_recov <= lockup_c;
    end
  end
`endif

endmodule
